drive_sequencer: RTL and testbench

Command-side counterpart to the motor controller. Accepts a start request, issues the 3-bit drive command code the motor controller consumes, and closes the loop on debounced reed-switch marker events. It drives a fixed course: forward leg, stop at magnet marker, timed pause, timed right turn, repeat for LEGS legs. It sits in the car top level between the user switches/reed input and the motor controller's command input.

---
 rtl/drive_sequencer.sv | 164 ++++++++++++++++
 tb/tb_drive_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/drive_sequencer.sv
// drive_sequencer: start-triggered course sequencer. Issues FORWARD until a
// debounced reed marker, pauses, turns right, and repeats for LEGS legs.
// Gives up with a fault if a forward leg runs past TIMEOUT_CYCLES.
module drive_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int PAUSE_CYCLES    = 10_000_000,
    parameter int TURN_CYCLES     = 50_000_000,
    parameter int TIMEOUT_CYCLES  = 1_000_000_000,
    parameter int LEGS            = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       reed_in,
    output logic [2:0] cmd,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [3:0] leg_count
);

    localparam int MAX_PT  = (PAUSE_CYCLES > TURN_CYCLES) ? PAUSE_CYCLES : TURN_CYCLES;
    localparam int MAX_PTO = (MAX_PT > TIMEOUT_CYCLES) ? MAX_PT : TIMEOUT_CYCLES;
    localparam int MAX_CYC = (MAX_PTO > DEBOUNCE_CYCLES) ? MAX_PTO : DEBOUNCE_CYCLES;
    localparam int TW      = $clog2(MAX_CYC) + 1;
    localparam int DW      = $clog2(DEBOUNCE_CYCLES) + 1;

    // Limits are "last cycle" values: the timer reads 0 on the first cycle in a state.
    localparam logic [TW-1:0] PAUSE_LAST = TW'(PAUSE_CYCLES - 1);
    localparam logic [TW-1:0] TURN_LAST  = TW'(TURN_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]    LEGS_4     = 4'(LEGS);

    localparam logic [2:0] CMD_STOP    = 3'b000;
    localparam logic [2:0] CMD_FORWARD = 3'b001;
    localparam logic [2:0] CMD_RIGHT   = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FWD,
        S_PAUSE,
        S_TURN,
        S_DONE,
        S_FAULT
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            clr_legs;
    logic            inc_legs;
    logic [TW-1:0]   timer;
    logic            reed_p0;
    logic            reed_p1;
    logic            reed_db;
    logic            reed_db_d;
    logic [DW-1:0]   db_cnt;
    logic            marker;

    function automatic logic [2:0] cmd_of(input state_t s);
        case (s)
            S_FWD:   cmd_of = CMD_FORWARD;
            S_TURN:  cmd_of = CMD_RIGHT;
            default: cmd_of = CMD_STOP;
        endcase
    endfunction

    // Reed path: two-flop synchronizer, then a level debouncer whose count
    // restarts whenever the synchronized level agrees with the accepted one.
    always_ff @(posedge clk) begin
        if (rst) begin
            reed_p0   <= 1'b0;
            reed_p1   <= 1'b0;
            reed_db   <= 1'b0;
            reed_db_d <= 1'b0;
            db_cnt    <= '0;
        end else begin
            // stage p0 -> p1: metastability settling
            reed_p0   <= reed_in;
            reed_p1   <= reed_p0;
            // debounce stage
            reed_db_d <= reed_db;
            if (reed_p1 != reed_db) begin
                if (db_cnt == DB_LAST) begin
                    reed_db <= reed_p1;
                    db_cnt  <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign marker = reed_db & ~reed_db_d;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; abort beats marker, marker beats timeout.
    always_comb begin
        state_d  = state_q;
        clr_legs = 1'b0;
        inc_legs = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d  = S_FWD;
                        clr_legs = 1'b1;
                    end
                end
                S_FWD: begin
                    if (marker) begin
                        state_d  = S_PAUSE;
                        inc_legs = 1'b1;
                    end else if (timer >= TO_LAST) begin
                        state_d = S_FAULT;
                    end
                end
                S_PAUSE: begin
                    if (timer >= PAUSE_LAST) state_d = (leg_count == LEGS_4) ? S_DONE : S_TURN;
                end
                S_TURN: begin
                    if (timer >= TURN_LAST) state_d = S_FWD;
                end
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Shared state timer: restarts on every state change and saturates.
    always_ff @(posedge clk) begin
        if (rst || (state_d != state_q)) timer <= '0;
        else if (timer != {TW{1'b1}})    timer <= timer + 1'b1;
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd       <= CMD_STOP;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
            leg_count <= '0;
        end else begin
            cmd   <= cmd_of(state_d);
            busy  <= (state_d == S_FWD) || (state_d == S_PAUSE) || (state_d == S_TURN);
            done  <= (state_d == S_DONE);
            fault <= (state_d == S_FAULT);
            if (clr_legs)      leg_count <= '0;
            else if (inc_legs) leg_count <= leg_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_drive_sequencer.sv
// Bench for drive_sequencer: a fixed course trace table, hand-written corner
// sequences, and a randomized run, all cross-checked against a cycle-count
// reference model of the course rules.
module tb_drive_sequencer;

    localparam int DB = 4;
    localparam int PC = 3;
    localparam int TC = 5;
    localparam int TO = 50;
    localparam int LG = 2;

    localparam int P_IDLE  = 0;
    localparam int P_FWD   = 1;
    localparam int P_PAUSE = 2;
    localparam int P_TURN  = 3;
    localparam int P_DONE  = 4;
    localparam int P_FAULT = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       reed_in;
    logic [2:0] cmd;
    logic       busy;
    logic       done;
    logic       fault;
    logic [3:0] leg_count;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: course phase, cycles spent in it, legs, and the
    // raw reed samples still inside the debounce window.
    int m_phase = P_IDLE;
    int m_el    = 0;
    int m_legs  = 0;
    bit m_db    = 1'b0;
    bit m_mk    = 1'b0;
    bit hist[0:DB];

    typedef struct {
        bit st;
        bit ab;
        bit rd;
        int n;
        int cmd;
        bit busy;
        bit done;
        int legs;
    } vec_t;

    vec_t tbl[10];

    drive_sequencer #(
        .DEBOUNCE_CYCLES(DB),
        .PAUSE_CYCLES(PC),
        .TURN_CYCLES(TC),
        .TIMEOUT_CYCLES(TO),
        .LEGS(LG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .reed_in(reed_in),
        .cmd(cmd),
        .busy(busy),
        .done(done),
        .fault(fault),
        .leg_count(leg_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    // Advance the model by one clock edge using the inputs sampled there.
    task automatic model_edge(input bit st, input bit ab, input bit rd, input bit rs);
        int prev;
        bit all_diff;
        bit new_db;
        if (rs) begin
            m_phase = P_IDLE;
            m_el    = 0;
            m_legs  = 0;
            m_db    = 1'b0;
            m_mk    = 1'b0;
            for (int i = 0; i <= DB; i++) hist[i] = 1'b0;
        end else begin
            prev = m_phase;
            if (ab) begin
                m_phase = P_IDLE;
            end else begin
                case (m_phase)
                    P_IDLE, P_DONE: if (st) begin
                        m_phase = P_FWD;
                        m_legs  = 0;
                    end
                    P_FWD: begin
                        if (m_mk) begin
                            m_legs  = m_legs + 1;
                            m_phase = P_PAUSE;
                        end else if (m_el + 1 >= TO) begin
                            m_phase = P_FAULT;
                        end
                    end
                    P_PAUSE: if (m_el + 1 >= PC) m_phase = (m_legs == LG) ? P_DONE : P_TURN;
                    P_TURN:  if (m_el + 1 >= TC) m_phase = P_FWD;
                    default: ;
                endcase
            end
            if (m_phase != prev) m_el = 0;
            else                 m_el = m_el + 1;
            // The accepted level flips once the DB oldest synchronized samples
            // (two edges of sync delay) all disagree with it.
            all_diff = 1'b1;
            for (int i = 0; i < DB; i++) if (hist[i] == m_db) all_diff = 1'b0;
            new_db = all_diff ? ~m_db : m_db;
            m_mk   = new_db & ~m_db;
            m_db   = new_db;
            for (int i = 0; i < DB; i++) hist[i] = hist[i+1];
            hist[DB] = rd;
        end
    endtask

    task automatic step(input bit st, input bit ab, input bit rd, input bit rs);
        int ecmd;
        start   = st;
        abort   = ab;
        reed_in = rd;
        rst     = rs;
        @(posedge clk);
        model_edge(st, ab, rd, rs);
        #1;
        ecmd = (m_phase == P_FWD) ? 1 : (m_phase == P_TURN) ? 4 : 0;
        chk("model_cmd", int'(cmd), ecmd);
        chk("model_busy", int'(busy), int'(m_phase == P_FWD || m_phase == P_PAUSE || m_phase == P_TURN));
        chk("model_done", int'(done), int'(m_phase == P_DONE));
        chk("model_fault", int'(fault), int'(m_phase == P_FAULT));
        chk("model_legs", int'(leg_count), m_legs);
    endtask

    initial begin
        int first;
        int n;
        bit rd;

        // Full two-leg run: {start, abort, reed, cycles, cmd, busy, done, legs}
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1, 1, 1'b1, 1'b0, 0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 6, 1, 1'b1, 1'b0, 0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 3, 0, 1'b1, 1'b0, 1};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1, 4, 1'b1, 1'b0, 1};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 4, 4, 1'b1, 1'b0, 1};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 2, 1, 1'b1, 1'b0, 1};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 6, 1, 1'b1, 1'b0, 1};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 3, 0, 1'b1, 1'b0, 2};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 1, 0, 1'b0, 1'b1, 2};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 6, 0, 1'b0, 1'b1, 2};

        start = 1'b0; abort = 1'b0; reed_in = 1'b0; rst = 1'b1;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("rst_cmd", int'(cmd), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_legs", int'(leg_count), 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < tbl[r].n; c++) begin
                step(tbl[r].st, tbl[r].ab, tbl[r].rd, 1'b0);
                chk($sformatf("tbl%0d_cmd", r), int'(cmd), tbl[r].cmd);
                chk($sformatf("tbl%0d_busy", r), int'(busy), int'(tbl[r].busy));
                chk($sformatf("tbl%0d_done", r), int'(done), int'(tbl[r].done));
                chk($sformatf("tbl%0d_legs", r), int'(leg_count), tbl[r].legs);
            end
        end

        // Bounce, then a steady hold: one marker, then abort in the second TURN cycle.
        step(1, 0, 0, 0);
        chk("restart_legs", int'(leg_count), 0);
        for (int i = 0; i < 20; i++) step(0, 0, (i % 4) < 2, 0);
        chk("bounce_no_marker", int'(leg_count), 0);
        first = -1;
        for (int j = 1; j <= 10; j++) begin
            step(0, 0, 1, 0);
            if (first < 0 && leg_count == 4'd1) first = j;
        end
        chk("bounce_latency", first, 7);
        chk("bounce_legs", int'(leg_count), 1);
        step(0, 0, 0, 0);
        chk("turn_before_abort", int'(cmd), 4);
        step(0, 1, 0, 0);
        chk("abort_turn_cmd", int'(cmd), 0);
        chk("abort_turn_busy", int'(busy), 0);
        chk("abort_turn_legs", int'(leg_count), 1);
        step(1, 0, 0, 0);
        chk("start_clears_legs", int'(leg_count), 0);
        chk("start_cmd", int'(cmd), 1);

        // No markers: timeout into FAULT; start ignored; abort recovers.
        n = 0;
        for (int k = 1; k <= 60 && n == 0; k++) begin
            step(0, 0, 0, 0);
            if (fault) n = k;
        end
        chk("timeout_latency", n, 50);
        chk("timeout_cmd", int'(cmd), 0);
        step(1, 0, 0, 0);
        chk("fault_ignores_start", int'(fault), 1);
        chk("fault_start_busy", int'(busy), 0);
        step(0, 1, 0, 0);
        chk("abort_fault_fault", int'(fault), 0);
        chk("abort_fault_busy", int'(busy), 0);
        chk("abort_fault_cmd", int'(cmd), 0);

        // Marker and abort on the same edge: abort wins, leg count untouched.
        step(1, 0, 0, 0);
        for (int r = 1; r <= 7; r++) step(0, r == 7, 1, 0);
        chk("mk_abort_busy", int'(busy), 0);
        chk("mk_abort_legs", int'(leg_count), 0);
        chk("mk_abort_cmd", int'(cmd), 0);
        for (int r = 0; r < 8; r++) step(0, 0, 0, 0);

        // Marker on the timeout edge: marker wins, then reset in PAUSE.
        step(1, 0, 0, 0);
        for (int r = 1; r <= 50; r++) step(0, 0, r >= 44, 0);
        chk("mk_timeout_cmd", int'(cmd), 0);
        chk("mk_timeout_fault", int'(fault), 0);
        chk("mk_timeout_legs", int'(leg_count), 1);
        chk("mk_timeout_busy", int'(busy), 1);
        step(0, 0, 0, 1);
        chk("midrst_cmd", int'(cmd), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_fault", int'(fault), 0);
        chk("midrst_legs", int'(leg_count), 0);
        for (int r = 0; r < 8; r++) step(0, 0, 1, 0);
        for (int r = 0; r < 8; r++) step(0, 0, 0, 0);
        chk("idle_reed_legs", int'(leg_count), 0);
        chk("idle_reed_cmd", int'(cmd), 0);

        // Randomized traffic against the model.
        rd = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) rd = ~rd;
            step($urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0, rd,
                 $urandom_range(0, 255) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
